// File: rtl/gshare_bht.sv
// gshare_bht
// Gshare branch direction predictor: 64-entry table of 2-bit saturating counters
// indexed by PC[7:2] XOR a 6-bit global history register.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   IF2_pc          fetch PC being predicted
//   hit             BTB hit for IF2_pc
//   IF2_Branch      BTB entry is a conditional branch
//   IF2_Jump        BTB entry is an unconditional jump
//   pc_imm_in       BTB target for IF2_pc
//   update_en       a conditional branch resolved in EX this cycle
//   EX_pc           PC of the resolved branch
//   EX_ghr          history snapshot that travelled with the resolved branch
//   EX_taken        resolved direction
//   predict_taken   fetch redirect request
//   predict_target  next fetch PC
//   IF2_ghr         current history, piped alongside IF2_pc
module gshare_bht (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] IF2_pc,
   input  logic        hit,
   input  logic        IF2_Branch,
   input  logic        IF2_Jump,
   input  logic [31:0] pc_imm_in,
   input  logic        update_en,
   input  logic [31:0] EX_pc,
   input  logic [5:0]  EX_ghr,
   input  logic        EX_taken,
   output logic        predict_taken,
   output logic [31:0] predict_target,
   output logic [5:0]  IF2_ghr
);

   logic [1:0] r_pht [64];
   logic [5:0] r_ghr;

   logic [5:0] w_ridx;
   logic [5:0] w_widx;
   logic [1:0] w_rctr;
   logic [1:0] w_wctr;
   logic [1:0] w_wctr_nxt;
   logic       w_unused_ex_pc;

   // Only PC[7:2] participates in the index.
   assign w_unused_ex_pc = ^{EX_pc[31:8], EX_pc[1:0]};

   assign w_ridx = IF2_pc[7:2] ^ r_ghr;
   // Write side uses the history the branch was predicted with, not the live GHR.
   assign w_widx = EX_pc[7:2] ^ EX_ghr;

   assign w_rctr = r_pht[w_ridx];
   assign w_wctr = r_pht[w_widx];

   always_comb begin
      w_wctr_nxt = w_wctr;
      if (EX_taken) begin
         if (w_wctr != 2'b11) w_wctr_nxt = w_wctr + 2'd1;
      end else begin
         if (w_wctr != 2'b00) w_wctr_nxt = w_wctr - 2'd1;
      end
   end

   // Read path sees registered state only, so a same-index update is not bypassed.
   assign predict_taken  = hit & (IF2_Jump | (IF2_Branch & w_rctr[1]));
   assign predict_target = predict_taken ? pc_imm_in : (IF2_pc + 32'd4);
   assign IF2_ghr        = r_ghr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) begin
            r_pht[i] <= 2'b01;
         end
      end else if (update_en) begin
         r_pht[w_widx] <= w_wctr_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ghr <= 6'd0;
      end else if (update_en) begin
         r_ghr <= {r_ghr[4:0], EX_taken};
      end
   end

endmodule

// File: tb/tb_gshare_bht.sv
module tb_gshare_bht;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] IF2_pc = '0;
   logic        hit = 1'b0;
   logic        IF2_Branch = 1'b0;
   logic        IF2_Jump = 1'b0;
   logic [31:0] pc_imm_in = '0;
   logic        update_en = 1'b0;
   logic [31:0] EX_pc = '0;
   logic [5:0]  EX_ghr = '0;
   logic        EX_taken = 1'b0;
   logic        predict_taken;
   logic [31:0] predict_target;
   logic [5:0]  IF2_ghr;

   int n_total = 0;
   int n_bad = 0;
   bit started = 1'b0;

   gshare_bht dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .IF2_pc         (IF2_pc),
      .hit            (hit),
      .IF2_Branch     (IF2_Branch),
      .IF2_Jump       (IF2_Jump),
      .pc_imm_in      (pc_imm_in),
      .update_en      (update_en),
      .EX_pc          (EX_pc),
      .EX_ghr         (EX_ghr),
      .EX_taken       (EX_taken),
      .predict_taken  (predict_taken),
      .predict_target (predict_target),
      .IF2_ghr        (IF2_ghr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integer counters and history.
   int m_pht [64];
   int m_ghr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) m_pht[i] <= 1;
         m_ghr <= 0;
      end else if (update_en) begin
         int idx;
         idx = (int'(EX_pc[7:2]) ^ int'(EX_ghr));
         if (EX_taken) m_pht[idx] <= (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
         else          m_pht[idx] <= (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
         m_ghr <= ((m_ghr * 2) % 64) + (EX_taken ? 1 : 0);
      end
   end

   always @(negedge clk) begin
      if (started) begin
         int  ridx;
         bit  ept;
         ridx = int'(IF2_pc[7:2]) ^ m_ghr;
         ept  = hit && (IF2_Jump || (IF2_Branch && m_pht[ridx] >= 2));
         chk("model_taken", {31'd0, predict_taken}, {31'd0, ept});
         chk("model_target", predict_target, ept ? pc_imm_in : IF2_pc + 32'd4);
         chk("model_ghr", {26'd0, IF2_ghr}, m_ghr[31:0]);
      end
   end

   function automatic logic [31:0] pc_for(input logic [5:0] idx, input logic [5:0] gh);
      return {24'd0, idx ^ gh, 2'b00};
   endfunction

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic [5:0] gh, input logic tk);
      update_en = 1'b1;
      EX_pc     = pc;
      EX_ghr    = gh;
      EX_taken  = tk;
      @(posedge clk);
      #2 update_en = 1'b0;
   endtask

   task automatic drive_if(input logic [31:0] pc, input logic h, input logic br, input logic jmp,
                           input logic [31:0] imm);
      IF2_pc     = pc;
      hit        = h;
      IF2_Branch = br;
      IF2_Jump   = jmp;
      pc_imm_in  = imm;
   endtask

   initial begin
      do_reset();
      started = 1'b1;

      // Post-reset prediction: weakly not-taken
      drive_if(32'h100, 1'b1, 1'b1, 1'b0, 32'h200);
      settle();
      chk("rst_br_taken", {31'd0, predict_taken}, 32'd0);
      chk("rst_br_target", predict_target, 32'h104);
      chk("rst_ghr", {26'd0, IF2_ghr}, 32'd0);

      drive_if(32'h100, 1'b1, 1'b0, 1'b1, 32'h200);
      settle();
      chk("jump_taken", {31'd0, predict_taken}, 32'd1);
      chk("jump_target", predict_target, 32'h200);
      drive_if(32'h100, 1'b0, 1'b0, 1'b1, 32'h200);
      settle();
      chk("miss_taken", {31'd0, predict_taken}, 32'd0);
      chk("miss_target", predict_target, 32'h104);

      // One taken update at index 0, then read index 1^1 = 0
      upd(32'h100, 6'd0, 1'b1);
      drive_if(32'h104, 1'b1, 1'b1, 1'b0, 32'h300);
      settle();
      chk("seq_ghr", {26'd0, IF2_ghr}, 32'h01);
      chk("seq_taken", {31'd0, predict_taken}, 32'd1);
      chk("seq_target", predict_target, 32'h300);

      // Saturation at index 5
      repeat (4) upd(32'h14, 6'd0, 1'b1);
      drive_if(pc_for(6'd5, 6'h1F), 1'b1, 1'b1, 1'b0, 32'h400);
      settle();
      chk("sat_hi_ghr", {26'd0, IF2_ghr}, 32'h1F);
      chk("sat_hi_taken", {31'd0, predict_taken}, 32'd1);
      upd(32'h14, 6'd0, 1'b0);
      drive_if(pc_for(6'd5, 6'h3E), 1'b1, 1'b1, 1'b0, 32'h400);
      settle();
      chk("sat_hi_nowrap", {31'd0, predict_taken}, 32'd1);
      repeat (4) upd(32'h14, 6'd0, 1'b0);
      drive_if(pc_for(6'd5, 6'h20), 1'b1, 1'b1, 1'b0, 32'h400);
      settle();
      chk("sat_lo_ghr", {26'd0, IF2_ghr}, 32'h20);
      chk("sat_lo_taken", {31'd0, predict_taken}, 32'd0);
      upd(32'h14, 6'd0, 1'b1);
      drive_if(pc_for(6'd5, 6'h01), 1'b1, 1'b1, 1'b0, 32'h400);
      settle();
      chk("sat_lo_nowrap", {31'd0, predict_taken}, 32'd0);
      upd(32'h14, 6'd0, 1'b1);
      drive_if(pc_for(6'd5, 6'h03), 1'b1, 1'b1, 1'b0, 32'h400);
      settle();
      chk("sat_lo_recover", {31'd0, predict_taken}, 32'd1);

      // Reset mid-operation
      do_reset();
      repeat (3) upd(32'h40, 6'd0, 1'b1);
      drive_if(pc_for(6'h10, 6'h07), 1'b1, 1'b1, 1'b0, 32'h600);
      settle();
      chk("pre_rst_ghr", {26'd0, IF2_ghr}, 32'h07);
      chk("pre_rst_taken", {31'd0, predict_taken}, 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ghr", {26'd0, IF2_ghr}, 32'd0);
      drive_if(32'h40, 1'b1, 1'b1, 1'b0, 32'h600);
      #1;
      chk("mid_rst_ctr", {31'd0, predict_taken}, 32'd0);
      // Updates requested while in reset must be ignored
      update_en = 1'b1;
      EX_pc     = 32'h40;
      EX_ghr    = 6'd0;
      EX_taken  = 1'b1;
      @(posedge clk);
      #2;
      chk("rst_ignore_ctr", {31'd0, predict_taken}, 32'd0);
      chk("rst_ignore_ghr", {26'd0, IF2_ghr}, 32'd0);
      drive_if(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h600);
      #1;
      chk("wrap_target", predict_target, 32'h0);
      update_en = 1'b0;
      settle();
      rst_n = 1'b1;

      // Same-index collision at index 0
      drive_if(32'h0, 1'b1, 1'b1, 1'b0, 32'h500);
      update_en = 1'b1;
      EX_pc     = 32'h0;
      EX_ghr    = 6'd0;
      EX_taken  = 1'b1;
      #1;
      chk("coll_same_cycle", {31'd0, predict_taken}, 32'd0);
      chk("coll_same_target", predict_target, 32'h4);
      @(posedge clk);
      #2 update_en = 1'b0;
      IF2_pc = 32'h4;
      #1;
      chk("coll_next_ghr", {26'd0, IF2_ghr}, 32'h01);
      chk("coll_next_cycle", {31'd0, predict_taken}, 32'd1);
      chk("coll_next_target", predict_target, 32'h500);

      // Mixed traffic, checked by the model every cycle
      for (int i = 0; i < 24; i++) begin
         drive_if(32'(i * 32'h1C), 1'(i % 5 != 0), 1'(i % 4 != 3), 1'(i % 7 == 0),
                  32'(32'h1000 + i * 32'h10));
         upd(32'(i * 32'h24), 6'(i * 7), 1'(i % 3 != 0));
      end
      settle();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
